// File: rtl/register_bank_mp_if.sv
// Bus bundle for register_bank_mp: read ports, write port and (with REGBANK_SCOREBOARD_EN) issue/busy signals.
// Decode/writeback logic uses the master modport; the register bank uses the slave modport.
interface register_bank_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] ReadRegister;
    logic [NUM_RD*DATA_W-1:0] ReadData;
    logic [ADDR_W-1:0]        WriteRegister;
    logic [DATA_W-1:0]        WriteData;
    logic                     RegWrite;
`ifdef REGBANK_SCOREBOARD_EN
    logic                     IssueValid;
    logic [ADDR_W-1:0]        IssueReg;
    logic [NUM_RD-1:0]        ReadBusy;
`endif

    modport master (
        output ReadRegister,
        output WriteRegister,
        output WriteData,
        output RegWrite,
`ifdef REGBANK_SCOREBOARD_EN
        output IssueValid,
        output IssueReg,
        input  ReadBusy,
`endif
        input  ReadData
    );

    modport slave (
        input  ReadRegister,
        input  WriteRegister,
        input  WriteData,
        input  RegWrite,
`ifdef REGBANK_SCOREBOARD_EN
        input  IssueValid,
        input  IssueReg,
        output ReadBusy,
`endif
        output ReadData
    );
endinterface

// File: rtl/register_bank_mp.sv
// Multi-read-port MIPS register file with write-first bypass and optional hardwired-zero r0.
// Define REGBANK_SCOREBOARD_EN to add the pending-write scoreboard (IssueValid/IssueReg/ReadBusy).
module register_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              Clock,
    input  logic              ResetN,
    register_bank_mp_if.slave bus
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    logic [DATA_W-1:0]        memArray_r [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0] readData_s;
    logic                     writeKeep_s;

    // A write to r0 is discarded when r0 is hardwired to zero
    assign writeKeep_s = bus.RegWrite &&
                         !((ZERO_REG != 0) && (bus.WriteRegister == ZERO_ADDR));

    // Storage array: synchronous clear, then committed writes
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                memArray_r[i] <= {DATA_W{1'b0}};
            end
        end else if (writeKeep_s) begin
            memArray_r[bus.WriteRegister] <= bus.WriteData;
        end
    end

`ifndef SYNTHESIS
    // Trace of every committed write
    always_ff @(posedge Clock) begin
        if (ResetN && writeKeep_s) begin
            $display("register_bank_mp: write r%0d = %h", bus.WriteRegister, bus.WriteData);
        end
    end
`endif

    // Read ports: zero beats bypass; bypass only outside reset
    always_comb begin
        readData_s = {(NUM_RD*DATA_W){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if ((ZERO_REG != 0) && (bus.ReadRegister[k*ADDR_W +: ADDR_W] == ZERO_ADDR)) begin
                readData_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if (ResetN && bus.RegWrite &&
                         (bus.WriteRegister == bus.ReadRegister[k*ADDR_W +: ADDR_W])) begin
                readData_s[k*DATA_W +: DATA_W] = bus.WriteData;
            end else begin
                readData_s[k*DATA_W +: DATA_W] = memArray_r[bus.ReadRegister[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign bus.ReadData = readData_s;

`ifdef REGBANK_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busyNext_s;
    logic [NUM_RD-1:0]   readBusy_s;

    // Next busy vector: writeback clears, issue sets afterwards so a newer producer wins
    always_comb begin
        busyNext_s = busy_r;
        if (bus.RegWrite) begin
            busyNext_s[bus.WriteRegister] = 1'b0;
        end else begin
            busyNext_s = busy_r;
        end
        if (bus.IssueValid) begin
            busyNext_s[bus.IssueReg] = 1'b1;
        end else begin
            busyNext_s[bus.IssueReg] = busyNext_s[bus.IssueReg];
        end
        if (ZERO_REG != 0) begin
            busyNext_s[0] = 1'b0;
        end else begin
            busyNext_s[0] = busyNext_s[0];
        end
    end

    // Busy state register
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busyNext_s;
        end
    end

    // A same-cycle writeback un-busies the register, matching the data bypass
    always_comb begin
        readBusy_s = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            readBusy_s[k] = busy_r[bus.ReadRegister[k*ADDR_W +: ADDR_W]] &
                            ~(bus.RegWrite &&
                              (bus.WriteRegister == bus.ReadRegister[k*ADDR_W +: ADDR_W]));
        end
    end

    assign bus.ReadBusy = readBusy_s;
`endif
endmodule

// File: tb/tb_register_bank_mp.sv
// Self-checking bench for register_bank_mp: a 32x32 two-port bank with zero r0 and an 8x16 four-port bank without.
module tb_register_bank_mp;
    logic clk = 1'b0;
    logic rstNA;
    logic rstNB;
    always #5 clk = ~clk;

    register_bank_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) busA ();
    register_bank_mp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) busB ();

    register_bank_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dutA (
        .Clock(clk), .ResetN(rstNA), .bus(busA));
    register_bank_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dutB (
        .Clock(clk), .ResetN(rstNB), .bus(busB));

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] expQA [$];
    logic [15:0] expQB [$];
    logic [15:0] modelB [8];
    int          passCnt = 0;
    int          totalCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic driveA(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                          input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        busA.RegWrite      = we;
        busA.WriteRegister = wr;
        busA.WriteData     = wd;
        busA.ReadRegister  = {r1, r0};
    endtask

    task automatic cycleB(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                          input logic [2:0] a0, input logic [2:0] a1,
                          input logic [2:0] a2, input logic [2:0] a3, input string tag);
        logic [2:0] a [4];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        @(negedge clk);
        busB.RegWrite      = we;
        busB.WriteRegister = wr;
        busB.WriteData     = wd;
        busB.ReadRegister  = {a3, a2, a1, a0};
        for (int p = 0; p < 4; p++) begin
            expQB.push_back((we && wr == a[p]) ? wd : modelB[a[p]]);
        end
        #2;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("%s.p%0d", tag, p), {16'h0, busB.ReadData[p*16 +: 16]},
                  {16'h0, expQB.pop_front()});
        end
        if (we) modelB[wr] = wd;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h1,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd7,  32'h12345678, 5'd0,  5'd7,  32'h0,        32'h12345678};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd7,  32'hCAFEF00D, 32'h12345678};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hCAFEF00D, 32'h0};
        vecs[8] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd6,  32'hFFFFFFFF, 32'h0};
        for (int i = 0; i < 8; i++) modelB[i] = 16'h0;

        rstNA = 1'b0;
        rstNB = 1'b0;
        busA.RegWrite = 1'b0; busA.WriteRegister = 5'd0; busA.WriteData = 32'h0; busA.ReadRegister = 10'h0;
        busB.RegWrite = 1'b0; busB.WriteRegister = 3'd0; busB.WriteData = 16'h0; busB.ReadRegister = 12'h0;
`ifdef REGBANK_SCOREBOARD_EN
        busA.IssueValid = 1'b0; busA.IssueReg = 5'd0;
        busB.IssueValid = 1'b0; busB.IssueReg = 3'd0;
`endif
        @(negedge clk);
        rstNA = 1'b1;
        rstNB = 1'b1;

        // Reset state straight after the first edge
        driveA(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        #2;
        check("reset.r5", busA.ReadData[31:0], 32'h0);
        check("reset.r31", busA.ReadData[63:32], 32'h0);

        // Random writes, one reset edge, then every register reads 0 on both ports
        for (int i = 0; i < 20; i++) begin
            driveA(1'b1, 5'($urandom_range(0, 31)), $urandom, 5'd0, 5'd0);
        end
        driveA(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        rstNA = 1'b0;
        @(negedge clk);
        rstNA = 1'b1;
        for (int i = 0; i < 32; i++) begin
            driveA(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            #2;
            check($sformatf("clr.r%0d.p0", i), busA.ReadData[31:0], 32'h0);
            check($sformatf("clr.r%0d.p1", 31 - i), busA.ReadData[63:32], 32'h0);
        end

        // Table-driven write/read/bypass/zero vectors
        for (int i = 0; i < 10; i++) begin
            driveA(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].r0, vecs[i].r1);
            expQA.push_back(vecs[i].e0);
            expQA.push_back(vecs[i].e1);
            #2;
            check($sformatf("vec%0d.p0", i), busA.ReadData[31:0], expQA.pop_front());
            check($sformatf("vec%0d.p1", i), busA.ReadData[63:32], expQA.pop_front());
        end

        // Reset on the same edge as a write: no bypass during reset, r3 clears
        driveA(1'b1, 5'd3, 32'h33, 5'd3, 5'd3);
        driveA(1'b1, 5'd3, 32'hAA, 5'd3, 5'd5);
        rstNA = 1'b0;
        #2;
        check("rstwr.gated.r3", busA.ReadData[31:0], 32'h33);
        check("rstwr.stored.r5", busA.ReadData[63:32], 32'hCAFEF00D);
        driveA(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
        rstNA = 1'b1;
        #2;
        check("rstwr.after.r3", busA.ReadData[31:0], 32'h0);
        check("rstwr.after.r5", busA.ReadData[63:32], 32'h0);

`ifdef REGBANK_SCOREBOARD_EN
        // Issue r9, then it is busy; writeback un-busies it
        driveA(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        busA.IssueValid = 1'b1; busA.IssueReg = 5'd9;
        #2;
        check("sb.issue.same", {31'h0, busA.ReadBusy[0]}, 32'h0);
        driveA(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        busA.IssueValid = 1'b0;
        #2;
        check("sb.busy.r9", {31'h0, busA.ReadBusy[0]}, 32'h1);
        check("sb.r0.notbusy", {31'h0, busA.ReadBusy[1]}, 32'h0);
        driveA(1'b1, 5'd9, 32'h99, 5'd9, 5'd9);
        #2;
        check("sb.wb.same", {30'h0, busA.ReadBusy}, 32'h0);
        driveA(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        #2;
        check("sb.wb.after", {31'h0, busA.ReadBusy[0]}, 32'h0);
        // Issue and writeback of r9 together: set wins
        driveA(1'b1, 5'd9, 32'h9A, 5'd0, 5'd0);
        busA.IssueValid = 1'b1; busA.IssueReg = 5'd9;
        driveA(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        busA.IssueValid = 1'b0;
        #2;
        check("sb.setwins", {31'h0, busA.ReadBusy[0]}, 32'h1);
        check("sb.setwins.data", busA.ReadData[31:0], 32'h9A);
        // r0 can never become busy
        driveA(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        busA.IssueValid = 1'b1; busA.IssueReg = 5'd0;
        driveA(1'b0, 5'd0, 32'h0, 5'd0, 5'd9);
        busA.IssueValid = 1'b0;
        #2;
        check("sb.r0.never", {31'h0, busA.ReadBusy[0]}, 32'h0);
        check("sb.r9.still", {31'h0, busA.ReadBusy[1]}, 32'h1);
        // Reset clears busy bits
        rstNA = 1'b0;
        driveA(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        rstNA = 1'b1;
        #2;
        check("sb.reset", {30'h0, busA.ReadBusy}, 32'h0);
`endif

        // Four-port bank without zero register: r0 writable, bypass and model sweep
        cycleB(1'b1, 3'd0, 16'hBEEF, 3'd0, 3'd1, 3'd0, 3'd7, "b.wr0");
        cycleB(1'b0, 3'd0, 16'h0,    3'd0, 3'd0, 3'd0, 3'd0, "b.rd0");
        for (int c = 0; c < 40; c++) begin
            cycleB(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $sformatf("b.rnd%0d", c));
        end
        cycleB(1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 3'd2, 3'd3, "b.all.lo");
        cycleB(1'b0, 3'd0, 16'h0, 3'd4, 3'd5, 3'd6, 3'd7, "b.all.hi");
        cycleB(1'b1, 3'd6, 16'h1234, 3'd6, 3'd6, 3'd6, 3'd6, "b.bypass.all");

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
